fb_arbiter: RTL and testbench

Single-port frame-buffer access arbiter for the GPU. It shares one synchronous-read frame-buffer RAM among three requesters:
- the VGA scanout reader,
- the rectangle fill engine (read-modify-write of packed pixel bytes),
- the EPP host port.

Scanout has absolute priority. Fill and EPP share the remaining slots round-robin, and fill may lock out EPP across an RMW pair. The block sits between the requesters and the `frame_buffer` memory inside `gpu`.

---
 rtl/gpu_fb_pkg.sv | 21 ++
 rtl/fb_arbiter.sv | 127 ++++++++++++
 tb/tb_fb_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/gpu_fb_pkg.sv
// Shared frame-buffer constants and types for the GPU memory path.
package gpu_fb_pkg;

  localparam int FB_ADDR_W = 13;
  localparam int FB_DATA_W = 8;

  // Owner of a read travelling through the RAM pipeline.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_SCAN = 2'd1,
    SRC_FILL = 2'd2,
    SRC_EPP  = 2'd3
  } fb_src_t;

  // Which of the two round-robin requesters was granted most recently.
  typedef enum logic {
    AB_FILL = 1'b0,
    AB_EPP  = 1'b1
  } fb_ab_t;

endpackage

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: scanout first, then fill/EPP round-robin
// with an optional fill lock, plus a two-stage read-return tag pipeline.
module fb_arbiter
  import gpu_fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              uclk,
  input  logic              rst,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_gnt,
  output logic              scan_rvalid,
  input  logic              fill_req,
  input  logic              fill_we,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_wdata,
  input  logic              fill_lock,
  output logic              fill_gnt,
  output logic              fill_rvalid,
  input  logic              epp_req,
  input  logic              epp_we,
  input  logic [ADDR_W-1:0] epp_addr,
  input  logic [DATA_W-1:0] epp_wdata,
  output logic              epp_gnt,
  output logic              epp_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  fb_ab_t              last_ab_q, last_ab_d;
  logic                lock_q, lock_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  fb_src_t             tag1_q, tag_d;
  fb_src_t             tag2_q;

  // NOTE: every output of a combinational block gets a default first so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    scan_gnt = 1'b0;
    fill_gnt = 1'b0;
    epp_gnt  = 1'b0;
    if (!rst) begin
      if (scan_req) begin
        scan_gnt = 1'b1;
      end else if (lock_q) begin
        fill_gnt = fill_req;
      end else if (fill_req && epp_req) begin
        if (last_ab_q == AB_FILL) epp_gnt  = 1'b1;
        else                      fill_gnt = 1'b1;
      end else begin
        fill_gnt = fill_req;
        epp_gnt  = epp_req;
      end
    end
  end

  always_comb begin
    last_ab_d   = last_ab_q;
    lock_d      = lock_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    tag_d       = SRC_NONE;

    if (fill_gnt)     last_ab_d = AB_FILL;
    else if (epp_gnt) last_ab_d = AB_EPP;

    // A withdrawn fill request releases the lock even without a grant.
    if (fill_gnt)      lock_d = fill_lock;
    else if (!fill_req) lock_d = 1'b0;

    if (scan_gnt) begin
      mem_addr_d = scan_addr;
      tag_d      = SRC_SCAN;
    end else if (fill_gnt) begin
      mem_addr_d  = fill_addr;
      mem_we_d    = fill_we;
      mem_wdata_d = fill_wdata;
      tag_d       = fill_we ? SRC_NONE : SRC_FILL;
    end else if (epp_gnt) begin
      mem_addr_d  = epp_addr;
      mem_we_d    = epp_we;
      mem_wdata_d = epp_wdata;
      tag_d       = epp_we ? SRC_NONE : SRC_EPP;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      last_ab_q   <= AB_FILL;
      lock_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      tag1_q      <= SRC_NONE;
      tag2_q      <= SRC_NONE;
    end else begin
      last_ab_q   <= last_ab_d;
      lock_q      <= lock_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      tag1_q      <= tag_d;
      tag2_q      <= tag1_q;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;

  // The RAM output lines up with the second tag stage; gate it so rdata is 0 when idle.
  assign scan_rvalid = (tag2_q == SRC_SCAN);
  assign fill_rvalid = (tag2_q == SRC_FILL);
  assign epp_rvalid  = (tag2_q == SRC_EPP);
  assign rdata       = (tag2_q != SRC_NONE) ? mem_rdata : '0;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed self-checking bench for fb_arbiter with a behavioural
// synchronous-read RAM attached to the mem_* port.
module tb_fb_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          uclk = 1'b0;
  logic          rst;
  logic          scan_req, fill_req, fill_we, fill_lock, epp_req, epp_we;
  logic [AW-1:0] scan_addr, fill_addr, epp_addr;
  logic [DW-1:0] fill_wdata, epp_wdata;
  logic          scan_gnt, scan_rvalid, fill_gnt, fill_rvalid, epp_gnt, epp_rvalid;
  logic [DW-1:0] rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  int tests_run    = 0;
  int tests_failed = 0;

  fb_arbiter dut (
    .uclk(uclk), .rst(rst),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt), .scan_rvalid(scan_rvalid),
    .fill_req(fill_req), .fill_we(fill_we), .fill_addr(fill_addr), .fill_wdata(fill_wdata),
    .fill_lock(fill_lock), .fill_gnt(fill_gnt), .fill_rvalid(fill_rvalid),
    .epp_req(epp_req), .epp_we(epp_we), .epp_addr(epp_addr), .epp_wdata(epp_wdata),
    .epp_gnt(epp_gnt), .epp_rvalid(epp_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 uclk = ~uclk;

  initial for (int i = 0; i < (1 << AW); i++) ram[i] = '0;

  always @(posedge uclk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // checks made a further 1 ns later, well clear of either edge.
  task automatic cyc();
    @(posedge uclk);
    #2;
  endtask

  task automatic idle_all();
    scan_req = 1'b0; fill_req = 1'b0; epp_req = 1'b0;
    fill_we = 1'b0; epp_we = 1'b0; fill_lock = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnts"},  {scan_gnt, fill_gnt, epp_gnt}, 3'b000);
    check({tag, "_rv"},    {scan_rvalid, fill_rvalid, epp_rvalid}, 3'b000);
    check({tag, "_we"},    mem_we, 1'b0);
  endtask

  initial begin
    // ---- reset: requests asserted, yet nothing is granted ----
    rst = 1'b1;
    scan_addr = 13'h0; fill_addr = 13'h0; epp_addr = 13'h0;
    fill_wdata = 8'h0; epp_wdata = 8'h0; fill_we = 1'b0; epp_we = 1'b0; fill_lock = 1'b0;
    scan_req = 1'b1; fill_req = 1'b1; epp_req = 1'b1;
    #3;
    check_quiet("rst");
    check("rst_addr",  mem_addr,  13'h0);
    check("rst_wdata", mem_wdata, 8'h0);
    check("rst_rdata", rdata,     8'h0);
    cyc(); idle_all(); rst = 1'b0; #1;
    check_quiet("idle0");
    cyc(); #1;
    check_quiet("idle1");
    check("idle_addr", mem_addr, 13'h0);

    // ---- EPP write 0xA5 @0x28, then read it back ----
    cyc(); epp_req = 1'b1; epp_we = 1'b1; epp_addr = 13'h028; epp_wdata = 8'hA5; #1;
    check("eppw_gnt", epp_gnt, 1'b1);
    cyc(); epp_we = 1'b0; #1;
    check("eppr_gnt",   epp_gnt,   1'b1);
    check("eppw_mwe",   mem_we,    1'b1);
    check("eppw_maddr", mem_addr,  13'h028);
    check("eppw_mwd",   mem_wdata, 8'hA5);
    cyc(); epp_req = 1'b0; #1;
    check("eppr_mwe",   mem_we,     1'b0);
    check("eppr_maddr", mem_addr,   13'h028);
    check("eppw_norv",  epp_rvalid, 1'b0);
    cyc(); #1;
    check("eppr_rv",    epp_rvalid, 1'b1);
    check("eppr_rdata", rdata,      8'hA5);
    cyc(); #1;
    check("eppr_rv_end", epp_rvalid, 1'b0);
    check("eppr_rd_end", rdata,      8'h00);

    // ---- scan and EPP together: scan wins three cycles, EPP then ----
    cyc(); scan_req = 1'b1; scan_addr = 13'h100; epp_req = 1'b1; epp_addr = 13'h028; #1;
    check("scan0", {scan_gnt, epp_gnt}, 2'b10);
    cyc(); #1;
    check("scan1", {scan_gnt, epp_gnt}, 2'b10);
    cyc(); #1;
    check("scan2", {scan_gnt, epp_gnt}, 2'b10);
    check("scan_rv0", scan_rvalid, 1'b1);
    cyc(); scan_req = 1'b0; #1;
    check("scan_epp", {scan_gnt, epp_gnt}, 2'b01);
    check("scan_rv1", scan_rvalid, 1'b1);
    cyc(); epp_req = 1'b0; #1;
    check("scan_rv2", scan_rvalid, 1'b1);
    cyc(); #1;
    check("scan_epp_rv", {scan_rvalid, epp_rvalid}, 2'b01);
    check("scan_epp_rd", rdata, 8'hA5);

    // ---- after reset, fill and EPP alternate starting with EPP ----
    cyc(); rst = 1'b1; #1;
    cyc(); rst = 1'b0;
    fill_req = 1'b1; fill_addr = 13'h010; epp_req = 1'b1; epp_addr = 13'h028; #1;
    check("rr0", {fill_gnt, epp_gnt}, 2'b01);
    cyc(); #1;
    check("rr1", {fill_gnt, epp_gnt}, 2'b10);
    cyc(); #1;
    check("rr2", {fill_gnt, epp_gnt}, 2'b01);
    check("rr_rv0", {fill_rvalid, epp_rvalid}, 2'b01);
    check("rr_rd0", rdata, 8'hA5);
    cyc(); #1;
    check("rr3", {fill_gnt, epp_gnt}, 2'b10);
    check("rr_rv1", {fill_rvalid, epp_rvalid}, 2'b10);
    cyc(); idle_all(); #1;
    check("rr_rv2", {fill_rvalid, epp_rvalid}, 2'b01);
    cyc(); #1;
    check("rr_rv3", {fill_rvalid, epp_rvalid}, 2'b10);

    // ---- fill RMW with lock; scan takes the gap; EPP waits for unlock ----
    cyc(); fill_req = 1'b1; fill_we = 1'b0; fill_addr = 13'h027; fill_lock = 1'b1; #1;
    check("lk_rd", {fill_gnt, epp_gnt}, 2'b10);
    cyc(); fill_we = 1'b1; fill_wdata = 8'h5A; fill_lock = 1'b0;
    scan_req = 1'b1; scan_addr = 13'h200; epp_req = 1'b1; epp_addr = 13'h028; #1;
    check("lk_scan0", {scan_gnt, fill_gnt, epp_gnt}, 3'b100);
    cyc(); #1;
    check("lk_scan1", {scan_gnt, fill_gnt, epp_gnt}, 3'b100);
    check("lk_fill_rv", fill_rvalid, 1'b1);
    cyc(); scan_req = 1'b0; #1;
    check("lk_wr", {fill_gnt, epp_gnt}, 2'b10);
    cyc(); fill_req = 1'b0; #1;
    check("lk_epp", epp_gnt, 1'b1);
    check("lk_mwe",   mem_we,    1'b1);
    check("lk_maddr", mem_addr,  13'h027);
    check("lk_mwd",   mem_wdata, 8'h5A);

    // ---- lock taken, then fill withdraws: lock drops one cycle later ----
    cyc(); fill_req = 1'b1; fill_we = 1'b0; fill_lock = 1'b1; #1;
    check("wd_fill", {fill_gnt, epp_gnt}, 2'b10);
    cyc(); fill_req = 1'b0; #1;
    check("wd_block", epp_gnt, 1'b0);
    check("wd_epp_rv", epp_rvalid, 1'b1);
    check("wd_epp_rd", rdata, 8'hA5);
    cyc(); #1;
    check("wd_epp", epp_gnt, 1'b1);
    check("wd_fill_rv", fill_rvalid, 1'b1);
    check("wd_fill_rd", rdata, 8'h5A);
    cyc(); idle_all(); #1;

    // ---- reset one cycle after a scan read grant drops the read ----
    cyc(); #1;
    cyc(); scan_req = 1'b1; scan_addr = 13'h030; #1;
    check("rs_gnt", scan_gnt, 1'b1);
    cyc(); scan_req = 1'b0; rst = 1'b1; #1;
    check_quiet("rs_now");
    check("rs_addr",  mem_addr, 13'h0);
    check("rs_rdata", rdata,    8'h0);
    cyc(); #1;
    check("rs_norv", scan_rvalid, 1'b0);
    cyc(); rst = 1'b0; #1;
    check_quiet("rs_after");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
